// File: rtl/axi_rd_txn_guard.sv
// axi_rd_txn_guard: passive AXI read-path monitor.
// Tracks outstanding reads, times out AR/first-beat/inter-beat, latches first error.
module axi_rd_txn_guard #(
  parameter int IdWidth  = 4,
  parameter int NumSlots = 8,
  parameter int CntWidth = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            enable_i,
  input  logic                            clear_i,
  input  logic                            ar_valid_i,
  input  logic                            ar_ready_i,
  input  logic [IdWidth-1:0]              ar_id_i,
  input  logic [7:0]                      ar_len_i,
  input  logic                            r_valid_i,
  input  logic                            r_ready_i,
  input  logic                            r_last_i,
  input  logic [IdWidth-1:0]              r_id_i,
  input  logic [CntWidth-1:0]             budget_ar_i,
  input  logic [CntWidth-1:0]             budget_first_i,
  input  logic [CntWidth-1:0]             budget_beat_i,
  output logic                            irq_o,
  output logic                            err_valid_o,
  output logic [2:0]                      err_kind_o,
  output logic [IdWidth-1:0]              err_id_o,
  output logic [$clog2(NumSlots+1)-1:0]   outstanding_o,
  output logic                            full_o
);

  localparam int OcW = $clog2(NumSlots + 1);
  localparam int IxW = $clog2(NumSlots);

  localparam logic [2:0] KArStall = 3'd1;
  localparam logic [2:0] KFirst   = 3'd2;
  localparam logic [2:0] KBeat    = 3'd3;
  localparam logic [2:0] KUnexp   = 3'd4;
  localparam logic [2:0] KOvf     = 3'd5;

  typedef logic [CntWidth-1:0] cnt_t;

  typedef struct packed {
    logic               valid;
    logic [IdWidth-1:0] id;
    logic [7:0]         left;
    logic [IxW-1:0]     ahead;
    logic               to;
    logic               seen;
    cnt_t               cnt;
  } slot_t;

  slot_t slot_q [NumSlots];
  slot_t slot_d [NumSlots];

  logic [NumSlots-1:0] hit;
  logic [NumSlots-1:0] tmo;
  logic [IxW-1:0]      hit_idx;
  logic [IxW-1:0]      free_idx;
  logic [IxW-1:0]      new_ahead;
  logic [OcW-1:0]      ahead_cnt;
  logic [OcW-1:0]      occ_d;
  logic [OcW-1:0]      occ_q;
  logic                full_q;

  logic r_fire, ar_fire, stall;
  logic r_hit, retire, any_free, alloc, ovf;
  logic beat;
  cnt_t bud;

  cnt_t ar_cnt_q, ar_cnt_d;
  logic ar_fired_q, ar_fired_d;
  logic ar_tmo;

  logic               ev;
  logic [2:0]         ev_kind;
  logic [IdWidth-1:0] ev_id;

  logic               err_valid_q;
  logic [2:0]         err_kind_q;
  logic [IdWidth-1:0] err_id_q;

  assign r_fire  = r_valid_i & r_ready_i;
  assign ar_fire = ar_valid_i & ar_ready_i;
  assign stall   = ar_valid_i & ~ar_ready_i;
  assign r_hit   = |hit;
  assign retire  = r_fire & r_hit & r_last_i;
  assign alloc   = ar_fire & any_free;
  assign ovf     = ar_fire & ~any_free;

  // Lowest-index matching head slot and lowest-index free slot.
  always_comb begin : lookup
    hit      = '0;
    hit_idx  = '0;
    free_idx = '0;
    any_free = 1'b0;
    for (int i = NumSlots - 1; i >= 0; i--) begin
      hit[i] = slot_q[i].valid &&
               slot_q[i].id == r_id_i &&
               slot_q[i].ahead == '0;
      if (hit[i]) hit_idx = IxW'(i);
      if (!slot_q[i].valid) begin
        free_idx = IxW'(i);
        any_free = 1'b1;
      end
    end
  end

  always_comb begin : ahead_calc
    ahead_cnt = '0;
    for (int i = 0; i < NumSlots; i++) begin
      if (slot_q[i].valid && slot_q[i].id == ar_id_i &&
          !(retire && hit_idx == IxW'(i)))
        ahead_cnt = ahead_cnt + OcW'(1);
    end
    new_ahead = IxW'(ahead_cnt);
  end

  always_comb begin : slot_next
    tmo   = '0;
    beat  = 1'b0;
    bud   = '0;
    occ_d = '0;
    for (int i = 0; i < NumSlots; i++) begin
      slot_d[i] = slot_q[i];
      beat = r_fire && r_hit && hit_idx == IxW'(i);
      bud  = slot_q[i].seen ? budget_beat_i : budget_first_i;
      tmo[i] = enable_i && slot_q[i].valid && !slot_q[i].to &&
               !beat && bud != '0 && slot_q[i].cnt == bud;
      if (slot_q[i].valid) begin
        if (beat) begin
          slot_d[i].cnt  = '0;
          slot_d[i].seen = 1'b1;
          if (r_last_i) slot_d[i].valid = 1'b0;
          else          slot_d[i].left  = slot_q[i].left - 8'd1;
        end else if (enable_i && !slot_q[i].to && !tmo[i] &&
                     slot_q[i].cnt != '1) begin
          slot_d[i].cnt = slot_q[i].cnt + cnt_t'(1);
        end
        if (tmo[i]) slot_d[i].to = 1'b1;
        if (retire && !beat && slot_q[i].id == r_id_i &&
            slot_q[i].ahead != '0)
          slot_d[i].ahead = slot_q[i].ahead - IxW'(1);
      end
      if (alloc && free_idx == IxW'(i)) begin
        slot_d[i].valid = 1'b1;
        slot_d[i].id    = ar_id_i;
        slot_d[i].left  = ar_len_i;
        slot_d[i].ahead = new_ahead;
        slot_d[i].to    = 1'b0;
        slot_d[i].seen  = 1'b0;
        slot_d[i].cnt   = '0;
      end
      occ_d = occ_d + OcW'(slot_d[i].valid);
    end
  end

  // Stall counter fires once per stall episode.
  always_comb begin : ar_stall
    ar_cnt_d   = ar_cnt_q;
    ar_fired_d = ar_fired_q;
    ar_tmo     = enable_i && stall && !ar_fired_q &&
                 budget_ar_i != '0 && ar_cnt_q == budget_ar_i;
    if (!stall) begin
      ar_cnt_d   = '0;
      ar_fired_d = 1'b0;
    end else begin
      if (enable_i && ar_cnt_q != '1) ar_cnt_d = ar_cnt_q + cnt_t'(1);
      if (ar_tmo) ar_fired_d = 1'b1;
    end
  end

  always_comb begin : ev_sel
    ev      = 1'b0;
    ev_kind = '0;
    ev_id   = '0;
    if (ar_tmo) begin
      ev      = 1'b1;
      ev_kind = KArStall;
      ev_id   = ar_id_i;
    end else if (r_fire && !r_hit) begin
      ev      = 1'b1;
      ev_kind = KUnexp;
      ev_id   = r_id_i;
    end else if (ovf) begin
      ev      = 1'b1;
      ev_kind = KOvf;
      ev_id   = ar_id_i;
    end else begin
      for (int i = NumSlots - 1; i >= 0; i--) begin
        if (tmo[i]) begin
          ev      = 1'b1;
          ev_kind = slot_q[i].seen ? KBeat : KFirst;
          ev_id   = slot_q[i].id;
        end
      end
    end
    ev = ev & enable_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumSlots; i++) slot_q[i] <= '0;
      ar_cnt_q    <= '0;
      ar_fired_q  <= 1'b0;
      err_valid_q <= 1'b0;
      err_kind_q  <= '0;
      err_id_q    <= '0;
      occ_q       <= '0;
      full_q      <= 1'b0;
    end else begin
      for (int i = 0; i < NumSlots; i++) slot_q[i] <= slot_d[i];
      ar_cnt_q   <= ar_cnt_d;
      ar_fired_q <= ar_fired_d;
      occ_q      <= occ_d;
      full_q     <= occ_d == OcW'(NumSlots);
      if (clear_i) begin
        err_valid_q <= 1'b0;
        err_kind_q  <= '0;
        err_id_q    <= '0;
      end else if (!err_valid_q && ev) begin
        err_valid_q <= 1'b1;
        err_kind_q  <= ev_kind;
        err_id_q    <= ev_id;
      end
    end
  end

  assign irq_o         = err_valid_q;
  assign err_valid_o   = err_valid_q;
  assign err_kind_o    = err_kind_q;
  assign err_id_o      = err_id_q;
  assign outstanding_o = occ_q;
  assign full_o        = full_q;

endmodule

// File: tb/tb_axi_rd_txn_guard.sv
// tb_axi_rd_txn_guard: directed plan steps plus random traffic
// checked against a transaction-level reference model.
module tb_axi_rd_txn_guard;
  localparam int IdW  = 4;
  localparam int NS   = 8;
  localparam int CW   = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0, enable = 1'b0, clear = 1'b0;
  logic ar_valid = 1'b0, ar_ready = 1'b0;
  logic r_valid = 1'b0, r_ready = 1'b0, r_last = 1'b0;
  logic [IdW-1:0] ar_id = '0, r_id = '0;
  logic [7:0] ar_len = '0;
  logic [CW-1:0] b_ar = '0, b_first = '0, b_beat = '0;
  logic irq, err_valid, full;
  logic [2:0] err_kind;
  logic [IdW-1:0] err_id;
  logic [3:0] outstanding;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  axi_rd_txn_guard #(.IdWidth(IdW), .NumSlots(NS), .CntWidth(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .clear_i(clear),
    .ar_valid_i(ar_valid), .ar_ready_i(ar_ready),
    .ar_id_i(ar_id), .ar_len_i(ar_len),
    .r_valid_i(r_valid), .r_ready_i(r_ready), .r_last_i(r_last),
    .r_id_i(r_id),
    .budget_ar_i(b_ar), .budget_first_i(b_first), .budget_beat_i(b_beat),
    .irq_o(irq), .err_valid_o(err_valid), .err_kind_o(err_kind),
    .err_id_o(err_id), .outstanding_o(outstanding), .full_o(full)
  );

  // Reference: slots ordered by acceptance sequence number per ID.
  bit m_v [NS];
  int m_id [NS];
  int m_seq [NS];
  int m_cnt [NS];
  bit m_seen [NS];
  bit m_to [NS];
  int m_arcnt;
  bit m_arfired;
  bit m_errv;
  int m_kind;
  int m_eid;
  int seq_ctr;

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_v[i] = 0; m_id[i] = 0; m_seq[i] = 0;
      m_cnt[i] = 0; m_seen[i] = 0; m_to[i] = 0;
    end
    m_arcnt = 0; m_arfired = 0;
    m_errv = 0; m_kind = 0; m_eid = 0;
  endtask

  task automatic model_step();
    int tgt, free, kind, eid, bud;
    bit rf, af, stall, ar_to, any, bt;
    bit sto [NS];
    if (!rst_n) begin
      model_reset();
      return;
    end
    rf = r_valid && r_ready;
    af = ar_valid && ar_ready;
    stall = ar_valid && !ar_ready;
    tgt = -1;
    free = -1;
    for (int i = 0; i < NS; i++) begin
      if (m_v[i] && m_id[i] == int'(r_id) &&
          (tgt < 0 || m_seq[i] < m_seq[tgt])) tgt = i;
      if (!m_v[i] && free < 0) free = i;
    end
    ar_to = enable && stall && !m_arfired &&
            b_ar != 0 && m_arcnt == int'(b_ar);
    for (int i = 0; i < NS; i++) begin
      bud = m_seen[i] ? int'(b_beat) : int'(b_first);
      bt = rf && tgt == i;
      sto[i] = enable && m_v[i] && !m_to[i] && !bt &&
               bud != 0 && m_cnt[i] == bud;
    end
    any = 0; kind = 0; eid = 0;
    if (ar_to) begin
      any = 1; kind = 1; eid = int'(ar_id);
    end else if (rf && tgt < 0) begin
      any = 1; kind = 4; eid = int'(r_id);
    end else if (af && free < 0) begin
      any = 1; kind = 5; eid = int'(ar_id);
    end else begin
      for (int i = 0; i < NS; i++)
        if (sto[i] && !any) begin
          any = 1; kind = m_seen[i] ? 3 : 2; eid = m_id[i];
        end
    end
    if (clear) m_errv = 0;
    else if (!m_errv && enable && any) begin
      m_errv = 1; m_kind = kind; m_eid = eid;
    end
    if (!stall) begin
      m_arcnt = 0; m_arfired = 0;
    end else begin
      if (enable && m_arcnt < CMAX) m_arcnt++;
      if (ar_to) m_arfired = 1;
    end
    for (int i = 0; i < NS; i++) begin
      if (!m_v[i]) continue;
      if (rf && tgt == i) begin
        m_cnt[i] = 0; m_seen[i] = 1;
        if (r_last) m_v[i] = 0;
      end else if (enable && !m_to[i] && m_cnt[i] < CMAX) begin
        m_cnt[i]++;
      end
      if (sto[i]) m_to[i] = 1;
    end
    if (af && free >= 0) begin
      m_v[free] = 1; m_id[free] = int'(ar_id);
      m_seq[free] = seq_ctr++; m_cnt[free] = 0;
      m_seen[free] = 0; m_to[free] = 0;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int occ;
    occ = 0;
    for (int i = 0; i < NS; i++) occ += int'(m_v[i]);
    chk("irq", 32'(irq), 32'(m_errv));
    chk("err_valid", 32'(err_valid), 32'(m_errv));
    if (m_errv) begin
      chk("err_kind", 32'(err_kind), 32'(m_kind));
      chk("err_id", 32'(err_id), 32'(m_eid));
    end
    chk("outstanding", 32'(outstanding), 32'(occ));
    chk("full", 32'(full), 32'(occ == NS));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_ar(int id, int len);
    ar_valid = 1'b1; ar_ready = 1'b1;
    ar_id = IdW'(id); ar_len = 8'(len);
    step();
    ar_valid = 1'b0; ar_ready = 1'b0;
  endtask

  task automatic do_r(int id, bit last);
    r_valid = 1'b1; r_ready = 1'b1;
    r_id = IdW'(id); r_last = last;
    step();
    r_valid = 1'b0; r_ready = 1'b0; r_last = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    int j;
    model_reset();
    seq_ctr = 0;
    step();
    step();
    chk("rst_irq", 32'(irq), 0);
    chk("rst_err_valid", 32'(err_valid), 0);
    chk("rst_outstanding", 32'(outstanding), 0);
    chk("rst_full", 32'(full), 0);
    rst_n = 1'b1;
    enable = 1'b1;
    step();

    // AR stall of 10 cycles with budget 4; cleared mid-stall, no recapture.
    b_ar = CW'(4);
    ar_valid = 1'b1; ar_ready = 1'b0; ar_id = IdW'(10);
    for (int k = 1; k <= 10; k++) begin
      clear = (k == 7);
      step();
      if (k == 4) chk("stall_pre", 32'(irq), 0);
      if (k == 5) begin
        chk("stall_irq", 32'(irq), 1);
        chk("stall_kind", 32'(err_kind), 1);
        chk("stall_id", 32'(err_id), 10);
      end
      if (k == 10) chk("stall_once", 32'(irq), 0);
    end
    clear = 1'b0; ar_valid = 1'b0; b_ar = '0;
    step();

    // Clean 4-beat burst.
    b_first = CW'(20); b_beat = CW'(20);
    do_ar(3, 3);
    chk("burst_out1", 32'(outstanding), 1);
    repeat (7) step();
    do_r(3, 0); do_r(3, 0); do_r(3, 0); do_r(3, 1);
    chk("burst_out0", 32'(outstanding), 0);
    chk("burst_noerr", 32'(err_valid), 0);

    // Inter-beat timeout, burst still retires.
    b_beat = CW'(5);
    do_ar(3, 3);
    do_r(3, 0); do_r(3, 0);
    repeat (7) step();
    chk("beat_kind", 32'(err_kind), 3);
    chk("beat_id", 32'(err_id), 3);
    do_r(3, 0); do_r(3, 1);
    chk("beat_out0", 32'(outstanding), 0);
    do_clear();
    chk("beat_clr", 32'(irq), 0);

    // Per-ID ordering.
    b_beat = CW'(20);
    do_ar(2, 0); do_ar(2, 1); do_ar(5, 0);
    chk("ord_out3", 32'(outstanding), 3);
    do_r(5, 1); do_r(2, 1); do_r(2, 0); do_r(2, 1);
    chk("ord_noerr", 32'(err_valid), 0);
    chk("ord_out0", 32'(outstanding), 0);
    do_r(2, 1);
    chk("unexp_kind", 32'(err_kind), 4);
    chk("unexp_id", 32'(err_id), 2);
    do_clear();

    // Fill all slots, then overflow.
    b_first = '0; b_beat = '0;
    for (int i = 0; i < NS; i++) do_ar(i, 0);
    chk("fill_full", 32'(full), 1);
    chk("fill_out", 32'(outstanding), NS);
    do_ar(7, 0);
    chk("ovf_kind", 32'(err_kind), 5);
    chk("ovf_id", 32'(err_id), 7);
    do_clear();
    chk("ovf_clr", 32'(irq), 0);
    chk("ovf_out", 32'(outstanding), NS);

    // Simultaneous AR stall and first-beat timeout; then reset mid-burst.
    rst_n = 1'b0; step(); rst_n = 1'b1;
    b_first = CW'(6); b_ar = CW'(3);
    do_ar(1, 3);
    for (int n = 1; n <= 7; n++) begin
      ar_valid = (n >= 4); ar_ready = 1'b0; ar_id = IdW'(9);
      step();
      if (n == 6) chk("simul_pre", 32'(err_valid), 0);
    end
    chk("simul_kind", 32'(err_kind), 1);
    chk("simul_id", 32'(err_id), 9);
    ar_valid = 1'b0;
    do_r(1, 0);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("mrst_irq", 32'(irq), 0);
    chk("mrst_valid", 32'(err_valid), 0);
    chk("mrst_kind", 32'(err_kind), 0);
    chk("mrst_id", 32'(err_id), 0);
    chk("mrst_out", 32'(outstanding), 0);
    chk("mrst_full", 32'(full), 0);
    do_r(1, 0);
    chk("mrst_unexp", 32'(err_kind), 4);
    do_clear();

    // Disabled monitor captures nothing.
    enable = 1'b0;
    do_r(6, 1);
    chk("dis_noerr", 32'(err_valid), 0);
    enable = 1'b1;

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        b_ar = CW'($urandom_range(0, 8));
        b_first = CW'($urandom_range(0, 15));
        b_beat = CW'($urandom_range(0, 8));
      end
      enable = ($urandom_range(0, 19) != 0);
      clear = ($urandom_range(0, 24) == 0);
      rst_n = ($urandom_range(0, 499) != 0);
      ar_valid = ($urandom_range(0, 2) == 0);
      ar_ready = 1'($urandom_range(0, 1));
      ar_id = IdW'($urandom_range(0, 3));
      ar_len = 8'($urandom_range(0, 255));
      r_valid = 1'($urandom_range(0, 1));
      r_ready = ($urandom_range(0, 3) != 0);
      r_last = ($urandom_range(0, 2) == 0);
      j = int'($urandom_range(0, NS - 1));
      if (m_v[j] && $urandom_range(0, 4) != 0) r_id = IdW'(m_id[j]);
      else r_id = IdW'($urandom_range(0, 3));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi_rd_txn_guard.md
Name: axi_rd_txn_guard

Overview:
- Passive AXI read-path monitor; snoops AR/R handshakes between master and slave, next to the slave guard.
- Tracks up to NumSlots outstanding reads, honouring per-ID ordering, and times out three phases: AR stall, AR accept to first R beat, and R beat to next R beat.
- Latches the first violation (kind plus ID) and raises a sticky interrupt until software clears it.
- Budgets come from the guard's config registers as plain inputs.

Parameters:
- IdWidth, 4, width of AXI ID.
- NumSlots, 8, max tracked outstanding reads (>=2).
- CntWidth, 16, width of phase counters and budgets.

Ports:
- clk_i in 1 clock.
- rst_ni in 1 reset: synchronous, active-low.
- enable_i in 1 monitoring enable.
- clear_i in 1 clears irq/error latch.
- ar_valid_i, ar_ready_i in 1 each; snooped AR handshake.
- ar_id_i in IdWidth AR ID.
- ar_len_i in 8 burst length-1.
- r_valid_i, r_ready_i, r_last_i in 1 each; snooped R handshake.
- r_id_i in IdWidth R ID.
- budget_ar_i in CntWidth AR stall budget.
- budget_first_i in CntWidth accept-to-first-beat budget.
- budget_beat_i in CntWidth inter-beat budget.
- A budget of 0 disables that check.
- irq_o out 1 sticky error interrupt.
- err_valid_o out 1 error latch valid.
- err_kind_o out 3 latched kind.
- err_id_o out IdWidth latched ID.
- outstanding_o out $clog2(NumSlots+1) valid slot count.
- full_o out 1 all slots valid.

Behaviour:
- Reset (rst_ni low at posedge) clears all slots, counters and the error latch.
- All outputs are 0 after reset.
- Reset mid-burst drops all tracking. R beats that arrive later are reported as unexpected.
- Error kinds:
  - 1 = AR stall.
  - 2 = first-beat timeout.
  - 3 = inter-beat timeout.
  - 4 = unexpected R (no matching slot).
  - 5 = overflow (AR accepted with no free slot).
- AR stall counter:
  - Increments each cycle with ar_valid_i & !ar_ready_i.
  - Zeroed on handshake or when ar_valid_i is low.
  - Kind 1 fires in the cycle counter == budget_ar_i with ar_valid_i & !ar_ready_i still true.
  - Fires once per stall; the counter saturates and holds until the stall ends.
- Slot fields: valid, id, beats_left (8b), ahead (number of older same-ID slots), timed_out, cnt (CntWidth).
- Allocation on AR handshake:
  - Takes the lowest-index slot free at cycle start.
  - Loads id, beats_left = ar_len_i, cnt = 0, timed_out = 0.
  - ahead = count of valid same-ID slots not retiring this cycle.
  - With no free slot: kind 5 with ar_id_i; the transaction is untracked. A slot freed in the same cycle does not count as free.
- R beat (r_valid_i & r_ready_i):
  - Targets the valid slot with id == r_id_i and ahead == 0.
  - No such slot: kind 4 with r_id_i.
  - On a hit, cnt is zeroed; beats_left is decremented unless r_last_i.
  - r_last_i retires the slot and decrements ahead of other valid same-ID slots. The r_last vs beats_left mismatch is not checked.
- Slot counting:
  - Each valid, !timed_out slot increments cnt every cycle without a beat to it; cnt saturates.
  - Active budget is budget_first_i before the first beat and budget_beat_i after it. A first_seen bit per slot selects between them.
  - When cnt == active budget (non-zero), the slot reports kind 2 or 3 and sets timed_out.
  - A timed-out slot stops counting but keeps tracking and still retires normally.
  - Slots with ahead > 0 count as well; the first-beat phase covers queueing.
- Error latch:
  - Captures only when err_valid_o == 0.
  - Simultaneous-event priority: kind 1 > 4 > 5 > 2/3 (lowest slot index first).
  - Once latched, irq_o = err_valid_o = 1 from the next cycle, held until clear_i.
  - clear_i has priority over a new capture in the same cycle; the table is untouched.
- enable_i low:
  - All counters hold and no errors are captured.
  - Allocation, retirement and the ordering bookkeeping continue.
- outstanding_o and full_o are registered and reflect the slot state after each edge.

Test Plan:
- budget_ar_i=4, ar_valid held with ar_ready low for 10 cycles -> irq_o rises 5 cycles after ar_valid, err_kind_o=1, err_id_o=ar_id_i; only one capture.
- AR id 3, len 3, budget_first_i=20; first R beat 8 cycles later, beats 1 cycle apart, last beat retires -> no error, outstanding_o 1->0.
- Same AR, budget_beat_i=5, 7-cycle gap after beat 2 -> kind 3, id 3; remaining beats still retire, outstanding_o returns to 0.
- Two ARs id 2 (len 0, len 1) then one id 5; R id 5, then id 2 x3 -> beats map to the oldest slot per ID, no error; an extra R id 2 -> kind 4.
- NumSlots=8: 8 ARs accepted without R, full_o=1; 9th AR id 7 -> kind 5, id 7; clear_i -> irq_o=0, outstanding_o stays 8.
- Simultaneous AR stall timeout and slot first-beat timeout in the same cycle -> kind 1 latched; rst_ni low mid-burst -> all outputs 0 next cycle.
